// File: rtl/vx_core_mem_bridge_pkg.sv
// Shared types and defaults for the core <-> L2 memory bridge.
// Structs match the default bridge parameters.
package vx_core_mem_bridge_pkg;

    localparam int MEM_DATA_W   = 512;
    localparam int MEM_ADDR_W   = 26;
    localparam int MEM_TAG_W    = 8;
    localparam int MEM_BYTEEN_W = MEM_DATA_W / 8;

    typedef struct packed {
        logic                    rw;
        logic [MEM_BYTEEN_W-1:0] byteen;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_DATA_W-1:0]   data;
        logic [MEM_TAG_W-1:0]    tag;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic [MEM_TAG_W-1:0]  tag;
    } mem_rsp_t;

    // Index width for an n-entry storage array; never zero.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_elastic_buf.sv
// Two-entry skid buffer. in_ready comes straight from a flop, so there is
// no combinational path from out_ready back to the producer.
module vx_elastic_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             empty_next
);

    logic [1:0]       cnt, cnt_next;
    logic             full;
    logic [WIDTH-1:0] e0, e1;
    logic             push, pop;

    assign push       = in_valid & ~full;
    assign pop        = out_valid & out_ready;
    assign in_ready   = ~full;
    assign out_valid  = (cnt != 2'd0);
    assign out_data   = e0;
    assign empty_next = (cnt_next == 2'd0);

    always_comb begin
        cnt_next = cnt;
        if (push && !pop)
            cnt_next = cnt + 2'd1;
        else if (pop && !push)
            cnt_next = cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 2'd0;
            full <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            full <= (cnt_next == 2'd2);
        end
    end

    // e0 is always the head; e1 only holds the second entry while full.
    always_ff @(posedge clk) begin
        if (pop && cnt == 2'd2)
            e0 <= e1;
        else if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
            e0 <= in_data;
        if (push && cnt == 2'd1 && !pop)
            e1 <= in_data;
    end

endmodule

// File: rtl/vx_fifo.sv
// Synchronous FIFO with registered full flag and no write-through bypass.
module vx_fifo
    import vx_core_mem_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             empty_next
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next;
    logic             full;
    logic             push, pop;

    assign push       = in_valid & ~full;
    assign pop        = out_valid & out_ready;
    assign in_ready   = ~full;
    assign out_valid  = (count != '0);
    assign out_data   = mem[rd_ptr];
    assign empty_next = (count_next == '0);

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/vx_core_mem_bridge.sv
// Core L1 <-> shared memory bridge: elastic request buffer, read throttle on
// outstanding reads, response FIFO and a registered busy flag for drain detection.
module vx_core_mem_bridge
    import vx_core_mem_bridge_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DATA_W,
    parameter int ADDR_WIDTH  = MEM_ADDR_W,
    parameter int TAG_WIDTH   = MEM_TAG_W,
    parameter int MAX_PENDING = 8,
    parameter int RSP_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,

    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,

    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic                    mem_req_ready,

    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    output logic                    mem_rsp_ready,

    output logic                    busy
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int REQ_W  = 1 + BE_W + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
    localparam int RSP_W  = DATA_WIDTH + TAG_WIDTH;
    localparam int PCNT_W = $clog2(MAX_PENDING + 1);

    generate
        if (MAX_PENDING < 1 || RSP_DEPTH < MAX_PENDING) begin : g_bad_cfg
            $error("vx_core_mem_bridge: need 1 <= MAX_PENDING <= RSP_DEPTH");
        end
    endgenerate

    logic [REQ_W-1:0]  req_in, req_head;
    logic              head_valid, head_ready, req_empty_next;
    logic [RSP_W-1:0]  rsp_out;
    logic              rsp_empty_next;
    logic [PCNT_W-1:0] pending, pending_next;
    logic              can_issue, rd_fire, rsp_fire;

    assign req_in = {core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag};

    vx_elastic_buf #(.WIDTH(REQ_W)) req_buf (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (core_req_valid),
        .in_data    (req_in),
        .in_ready   (core_req_ready),
        .out_valid  (head_valid),
        .out_data   (req_head),
        .out_ready  (head_ready),
        .empty_next (req_empty_next)
    );

    assign {mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag} = req_head;

    // A throttled read stalls the head, so writes queued behind it wait too.
    assign can_issue     = mem_req_rw | (pending < PCNT_W'(MAX_PENDING));
    assign mem_req_valid = head_valid & can_issue;
    assign head_ready    = mem_req_ready & can_issue;

    assign rd_fire  = mem_req_valid & mem_req_ready & ~mem_req_rw;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    always_comb begin
        pending_next = pending;
        case ({rd_fire, rsp_fire})
            2'b10:   pending_next = pending + PCNT_W'(1);
            2'b01:   pending_next = (pending == '0) ? '0 : pending - PCNT_W'(1);
            default: pending_next = pending;
        endcase
    end

    vx_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) rsp_fifo (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (mem_rsp_valid),
        .in_data    ({mem_rsp_data, mem_rsp_tag}),
        .in_ready   (mem_rsp_ready),
        .out_valid  (core_rsp_valid),
        .out_data   (rsp_out),
        .out_ready  (core_rsp_ready),
        .empty_next (rsp_empty_next)
    );

    assign {core_rsp_data, core_rsp_tag} = rsp_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            busy    <= 1'b0;
        end else begin
            pending <= pending_next;
            busy    <= (pending_next != '0) | ~req_empty_next | ~rsp_empty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(rsp_fire && pending == '0))
                else $error("vx_core_mem_bridge: memory response with no read pending");
        end
    end

endmodule

// File: tb/tb_vx_core_mem_bridge.sv
// Directed bench for vx_core_mem_bridge: latency, throttle, backpressure, response FIFO, reset.
module tb_vx_core_mem_bridge;
    import vx_core_mem_bridge_pkg::*;

    typedef logic [511:0] w_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                    core_req_valid = 1'b0, core_req_rw = 1'b0;
    logic [MEM_BYTEEN_W-1:0] core_req_byteen = '1;
    logic [MEM_ADDR_W-1:0]   core_req_addr = '0;
    logic [MEM_DATA_W-1:0]   core_req_data = '0;
    logic [MEM_TAG_W-1:0]    core_req_tag = '0;
    logic                    core_req_ready;
    logic                    core_rsp_valid;
    logic [MEM_DATA_W-1:0]   core_rsp_data;
    logic [MEM_TAG_W-1:0]    core_rsp_tag;
    logic                    core_rsp_ready = 1'b1;
    logic                    mem_req_valid, mem_req_rw;
    logic [MEM_BYTEEN_W-1:0] mem_req_byteen;
    logic [MEM_ADDR_W-1:0]   mem_req_addr;
    logic [MEM_DATA_W-1:0]   mem_req_data;
    logic [MEM_TAG_W-1:0]    mem_req_tag;
    logic                    mem_req_ready = 1'b1;
    logic                    mem_rsp_valid = 1'b0;
    logic [MEM_DATA_W-1:0]   mem_rsp_data = '0;
    logic [MEM_TAG_W-1:0]    mem_rsp_tag = '0;
    logic                    mem_rsp_ready;
    logic                    busy;

    vx_core_mem_bridge dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
        .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
        .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input w_t got, input w_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: logs mem-side transfers, tracks owed responses, checks stall stability.
    mem_req_t    mq[$];
    int          owed = 0;
    logic        stall_prev = 1'b0;
    logic [99:0] held = '0;
    wire  [99:0] req_snap = {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, mem_req_data[63:0]};

    always @(negedge clk) begin
        if (stall_prev && !reset) chk("req_stable", w_t'(req_snap), w_t'(held));
        stall_prev <= mem_req_valid & ~mem_req_ready & ~reset;
        held       <= req_snap;
        if (!reset && mem_req_valid && mem_req_ready)
            mq.push_back({mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag});
        if (reset)
            owed <= 0;
        else
            owed <= owed + ((mem_req_valid && mem_req_ready && !mem_req_rw) ? 1 : 0)
                         - ((mem_rsp_valid && mem_rsp_ready) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rw, input logic [MEM_ADDR_W-1:0] addr, input logic [7:0] tag);
        int n = 0;
        core_req_valid = 1'b1;
        core_req_rw    = rw;
        core_req_addr  = addr;
        core_req_tag   = tag;
        core_req_data  = MEM_DATA_W'({addr, tag});
        while (!core_req_ready && n < 300) begin
            tick();
            n++;
        end
        if (!core_req_ready) chk("send_timeout", w_t'(0), w_t'(1));
        else tick();
        core_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        core_req_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b1;
        core_rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int         mbase;
    logic [3:0] pat = 4'b1001;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mem_req_valid", w_t'(mem_req_valid), w_t'(0));
        chk("rst_core_rsp_valid", w_t'(core_rsp_valid), w_t'(0));
        chk("rst_busy", w_t'(busy), w_t'(0));
        reset = 1'b0;
        tick();
        chk("rst_core_req_ready", w_t'(core_req_ready), w_t'(1));
        chk("rst_mem_rsp_ready", w_t'(mem_rsp_ready), w_t'(1));
        chk("rst_pending", w_t'(dut.pending), w_t'(0));

        // 1: single read round trip
        send(1'b0, 26'h10, 8'h3);
        chk("t1_valid", w_t'(mem_req_valid), w_t'(1));
        chk("t1_addr", w_t'(mem_req_addr), w_t'(26'h10));
        chk("t1_tag", w_t'(mem_req_tag), w_t'(8'h3));
        chk("t1_rw", w_t'(mem_req_rw), w_t'(0));
        chk("t1_busy_early", w_t'(busy), w_t'(1));
        tick();
        chk("t1_pending1", w_t'(dut.pending), w_t'(1));
        chk("t1_valid_gone", w_t'(mem_req_valid), w_t'(0));
        chk("t1_busy", w_t'(busy), w_t'(1));
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {64{8'hAA}};
        mem_rsp_tag   = 8'h3;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t1_rsp_valid", w_t'(core_rsp_valid), w_t'(1));
        chk("t1_rsp_data", w_t'(core_rsp_data), w_t'({64{8'hAA}}));
        chk("t1_rsp_tag", w_t'(core_rsp_tag), w_t'(8'h3));
        chk("t1_pending0", w_t'(dut.pending), w_t'(0));
        tick();
        chk("t1_rsp_drained", w_t'(core_rsp_valid), w_t'(0));
        chk("t1_busy_low", w_t'(busy), w_t'(0));

        // 2: throttle at 8 outstanding reads
        do_reset();
        mbase = mq.size();
        for (int i = 0; i < 10; i++) send(1'b0, MEM_ADDR_W'(32'h200 + i), 8'(i));
        chk("t2_ready_low", w_t'(core_req_ready), w_t'(0));
        repeat (3) tick();
        chk("t2_issued8", w_t'(mq.size() - mbase), w_t'(8));
        chk("t2_held", w_t'(mem_req_valid), w_t'(0));
        chk("t2_pending8", w_t'(dut.pending), w_t'(8));
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 8'h0;
        tick();
        mem_rsp_valid = 1'b0;
        chk("t2_9th_valid", w_t'(mem_req_valid), w_t'(1));
        chk("t2_9th_tag", w_t'(mem_req_tag), w_t'(8));
        tick();
        chk("t2_issued9", w_t'(mq.size() - mbase), w_t'(9));
        chk("t2_10th_held", w_t'(mem_req_valid), w_t'(0));
        chk("t2_pending_again", w_t'(dut.pending), w_t'(8));

        // 3: writes queued behind a throttled read
        do_reset();
        mbase = mq.size();
        fork
            begin
                for (int i = 0; i < 9; i++) send(1'b0, MEM_ADDR_W'(32'h300 + i), 8'(i));
                for (int i = 0; i < 4; i++) send(1'b1, MEM_ADDR_W'(32'h400 + i), 8'(8'h20 + i));
            end
            begin
                repeat (16) tick();
                chk("t3_only_reads", w_t'(mq.size() - mbase), w_t'(8));
                chk("t3_blocked", w_t'(mem_req_valid), w_t'(0));
                chk("t3_req_full", w_t'(core_req_ready), w_t'(0));
                mem_rsp_valid = 1'b1;
                tick();
                mem_rsp_valid = 1'b0;
                repeat (8) tick();
            end
        join
        chk("t3_total", w_t'(mq.size() - mbase), w_t'(13));
        if (mq.size() >= mbase + 13) begin
            chk("t3_read_first", w_t'({mq[mbase+8].rw, mq[mbase+8].tag}), w_t'({1'b0, 8'h8}));
            for (int k = 0; k < 4; k++)
                chk("t3_write", w_t'({mq[mbase+9+k].rw, mq[mbase+9+k].tag}), w_t'({1'b1, 8'(8'h20 + k)}));
        end
        chk("t3_pending", w_t'(dut.pending), w_t'(8));

        // 4: request backpressure 1,0,0,1 over a mixed 20-request stream
        do_reset();
        mbase = mq.size();
        fork
            for (int i = 0; i < 20; i++) send(i % 3 == 0, MEM_ADDR_W'(32'h100 + i), 8'(i));
            for (int c = 0; c < 200 && mq.size() < mbase + 20; c++) begin
                mem_req_ready = pat[c % 4];
                mem_rsp_valid = (owed > 0);
                tick();
            end
        join
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        chk("t4_count", w_t'(mq.size() - mbase), w_t'(20));
        if (mq.size() >= mbase + 20)
            for (int i = 0; i < 20; i++)
                chk("t4_order", w_t'({mq[mbase+i].rw, mq[mbase+i].addr, mq[mbase+i].tag}),
                    w_t'({i % 3 == 0, MEM_ADDR_W'(32'h100 + i), 8'(i)}));

        // 5: response FIFO fills under core backpressure
        do_reset();
        core_rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, MEM_ADDR_W'(32'h500 + i), 8'(i));
        repeat (2) tick();
        chk("t5_rsp_ready_init", w_t'(mem_rsp_ready), w_t'(1));
        for (int i = 0; i < 8; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = 8'(8'h40 + i);
            mem_rsp_data  = MEM_DATA_W'(i * 7 + 1);
            tick();
            chk("t5_rsp_ready", w_t'(mem_rsp_ready), w_t'(i < 7));
        end
        mem_rsp_valid  = 1'b0;
        core_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_out_valid", w_t'(core_rsp_valid), w_t'(1));
            chk("t5_out_tag", w_t'(core_rsp_tag), w_t'(8'h40 + i));
            chk("t5_out_data", w_t'(core_rsp_data), w_t'(i * 7 + 1));
            tick();
        end
        chk("t5_empty", w_t'(core_rsp_valid), w_t'(0));
        chk("t5_busy_low", w_t'(busy), w_t'(0));

        // 6: reset with reads pending and requests buffered
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, MEM_ADDR_W'(32'h600 + i), 8'(i));
        repeat (2) tick();
        mem_req_ready = 1'b0;
        send(1'b0, 26'h700, 8'h70);
        send(1'b1, 26'h701, 8'h71);
        chk("t6_pending3", w_t'(dut.pending), w_t'(3));
        chk("t6_buf_full", w_t'(core_req_ready), w_t'(0));
        mbase = mq.size();
        reset = 1'b1;
        tick();
        chk("t6_mem_req_valid", w_t'(mem_req_valid), w_t'(0));
        chk("t6_core_rsp_valid", w_t'(core_rsp_valid), w_t'(0));
        chk("t6_pending0", w_t'(dut.pending), w_t'(0));
        chk("t6_busy0", w_t'(busy), w_t'(0));
        reset = 1'b0;
        mem_req_ready = 1'b1;
        repeat (5) tick();
        chk("t6_no_stale", w_t'(mq.size() - mbase), w_t'(0));
        chk("t6_ready", w_t'(core_req_ready), w_t'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
